// File: rtl/rob_pkg.sv
// Shared encodings for the wide-commit reorder buffer.
// Holds the instruction type codes, the FSM states and the helper predicates.
package rob_pkg;

  typedef enum logic [2:0] {
    TYP_ALU = 3'd0,
    TYP_BR  = 3'd1,
    TYP_JMP = 3'd2,
    TYP_LD  = 3'd3,
    TYP_ST  = 3'd4
  } rob_type_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Branches and jumps carry a predicted PC that must be checked at commit.
  function automatic logic is_ctrl(input logic [2:0] t);
    return (t == TYP_BR) || (t == TYP_JMP);
  endfunction

  function automatic logic is_rf_simple(input logic [2:0] t);
    return (t == TYP_ALU) || (t == TYP_LD);
  endfunction

endpackage

// File: rtl/rob_cmt_sel.sv
// Commit slot selection for the head and head+1 entries, including the
// mispredict check on a head branch or jump.
module rob_cmt_sel
  import rob_pkg::*;
#(
  parameter int CMT_W = 2
) (
  input  logic        h0_busy,
  input  logic        h0_ready,
  input  logic [2:0]  h0_type,
  input  logic [31:0] h0_prd_pc,
  input  logic [31:0] h0_rel_pc,
  input  logic        h1_busy,
  input  logic        h1_ready,
  input  logic [2:0]  h1_type,
  output logic        slot0_rf,
  output logic        slot0_st,
  output logic        slot1_rf,
  output logic        flush_req,
  output logic [1:0]  retire_cnt
);

  localparam logic DUAL = (CMT_W == 2);

  logic h0_go;
  logic h0_ctrl;
  logic mispredict;
  logic h1_go;

  assign h0_go      = h0_busy && h0_ready;
  assign h0_ctrl    = is_ctrl(h0_type);
  assign mispredict = h0_go && h0_ctrl && (h0_prd_pc != h0_rel_pc);
  // Slot 1 only pairs behind a non-control head and only for plain RF writers.
  assign h1_go      = DUAL && h0_go && !h0_ctrl && h1_busy && h1_ready && is_rf_simple(h1_type);

  always_comb begin
    slot0_rf   = FALSE;
    slot0_st   = FALSE;
    slot1_rf   = h1_go;
    flush_req  = mispredict;
    retire_cnt = 2'd0;
    if (h0_go) begin
      slot0_rf = is_rf_simple(h0_type) || (h0_type == TYP_JMP);
      slot0_st = (h0_type == TYP_ST);
      if (!mispredict) begin
        retire_cnt = h1_go ? 2'd2 : 2'd1;
      end
    end
  end

endmodule

// File: rtl/rob_wide_cmt.sv
// Reorder buffer with up to two in-order commits per cycle and a
// mispredict flush that waits for the LSB to discard speculative entries.
module rob_wide_cmt
  import rob_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ROB_AW = 4,
  parameter int CMT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic [5:0]        alloc_code,
  input  logic [2:0]        alloc_type,
  input  logic [4:0]        alloc_rd,
  input  logic [31:0]       alloc_prd_pc,
  output logic              alloc_ready,
  output logic [ROB_AW-1:0] alloc_id,
  input  logic              ex_cdb_flag,
  input  logic [ROB_AW-1:0] ex_cdb_id,
  input  logic [31:0]       ex_cdb_val,
  input  logic [31:0]       ex_cdb_rel_pc,
  input  logic              ld_cdb_flag,
  input  logic [ROB_AW-1:0] ld_cdb_id,
  input  logic [31:0]       ld_cdb_val,
  input  logic              st_rdy_flag,
  input  logic [ROB_AW-1:0] st_rdy_id,
  output logic              cmt0_rf_flag,
  output logic [4:0]        cmt0_rd,
  output logic [ROB_AW-1:0] cmt0_id,
  output logic [31:0]       cmt0_val,
  output logic              cmt1_rf_flag,
  output logic [4:0]        cmt1_rd,
  output logic [ROB_AW-1:0] cmt1_id,
  output logic [31:0]       cmt1_val,
  output logic              cmt_st_flag,
  output logic [ROB_AW-1:0] cmt_st_id,
  output logic              flush_flag,
  output logic              flush_stall,
  output logic [31:0]       flush_pc,
  input  logic              lsb_clear_done,
  input  logic [ROB_AW-1:0] q1_id,
  input  logic [ROB_AW-1:0] q2_id,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [31:0]       q1_val,
  output logic [31:0]       q2_val
);

  localparam logic [ROB_AW:0]   FULL_CNT = (ROB_AW + 1)'(DEPTH);
  localparam logic [ROB_AW+1:0] DEPTH_W  = (ROB_AW + 2)'(DEPTH);

  logic [ROB_AW-1:0] head_reg;
  logic [ROB_AW-1:0] tail_reg;
  logic [ROB_AW:0]   count_reg;
  rob_state_e        state_reg;

  logic [DEPTH-1:0]  busy_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic [2:0]        type_arr [DEPTH];
  logic [4:0]        rd_arr   [DEPTH];
  logic [31:0]       val_arr  [DEPTH];
  logic [31:0]       prd_arr  [DEPTH];
  logic [31:0]       rel_arr  [DEPTH];

  logic [ROB_AW-1:0] head1;
  logic              run;
  logic              alloc_do;
  logic              clear_all;
  logic [ROB_AW+1:0] occ_next;

  logic              slot0_rf;
  logic              slot0_st;
  logic              slot1_rf;
  logic              flush_req;
  logic [1:0]        retire_cnt;

  // The opcode travels with decode but commit decisions use only the type.
  logic unused_code;
  assign unused_code = ^alloc_code;

  assign head1     = head_reg + ROB_AW'(1);
  assign run       = (state_reg == ST_RUN);
  assign alloc_do  = run && alloc_valid && (count_reg != FULL_CNT);
  assign clear_all = !run && lsb_clear_done;

  assign occ_next    = {1'b0, count_reg} + {{(ROB_AW + 1){1'b0}}, alloc_valid};
  assign alloc_ready = (occ_next < DEPTH_W);
  assign alloc_id    = tail_reg;

  assign q1_ready = ready_vec[q1_id];
  assign q2_ready = ready_vec[q2_id];
  assign q1_val   = val_arr[q1_id];
  assign q2_val   = val_arr[q2_id];

  rob_cmt_sel #(
    .CMT_W (CMT_W)
  ) u_sel (
    .h0_busy    (busy_vec[head_reg]),
    .h0_ready   (ready_vec[head_reg]),
    .h0_type    (type_arr[head_reg]),
    .h0_prd_pc  (prd_arr[head_reg]),
    .h0_rel_pc  (rel_arr[head_reg]),
    .h1_busy    (busy_vec[head1]),
    .h1_ready   (ready_vec[head1]),
    .h1_type    (type_arr[head1]),
    .slot0_rf   (slot0_rf),
    .slot0_st   (slot0_st),
    .slot1_rf   (slot1_rf),
    .flush_req  (flush_req),
    .retire_cnt (retire_cnt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic        hit_alloc;
      logic        hit_ret;
      logic        hit_ex;
      logic        hit_ld;
      logic        hit_st;
      logic        busy_reg;
      logic        ready_reg;
      logic [2:0]  type_reg;
      logic [4:0]  rd_reg;
      logic [31:0] val_reg;
      logic [31:0] prd_reg;
      logic [31:0] rel_reg;

      assign hit_alloc = alloc_do && (tail_reg == ROB_AW'(gi));
      assign hit_ret   = run && (((retire_cnt != 2'd0) && (head_reg == ROB_AW'(gi))) ||
                                 ((retire_cnt == 2'd2) && (head1 == ROB_AW'(gi))));
      assign hit_ex    = run && busy_reg && ex_cdb_flag && (ex_cdb_id == ROB_AW'(gi));
      // Same-id collision: the ALU bus has priority over the load bus.
      assign hit_ld    = run && busy_reg && ld_cdb_flag && (ld_cdb_id == ROB_AW'(gi)) && !hit_ex;
      assign hit_st    = run && busy_reg && st_rdy_flag && (st_rdy_id == ROB_AW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
          type_reg  <= 3'd0;
          rd_reg    <= 5'd0;
          val_reg   <= 32'd0;
          prd_reg   <= 32'd0;
          rel_reg   <= 32'd0;
        end else if (rdy) begin
          if (clear_all) begin
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
          end else if (hit_alloc) begin
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
            type_reg  <= alloc_type;
            rd_reg    <= alloc_rd;
            prd_reg   <= alloc_prd_pc;
          end else if (hit_ret) begin
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
          end else begin
            if (hit_ex) begin
              val_reg   <= ex_cdb_val;
              rel_reg   <= ex_cdb_rel_pc;
              ready_reg <= 1'b1;
            end else if (hit_ld) begin
              val_reg   <= ld_cdb_val;
              ready_reg <= 1'b1;
            end
            if (hit_st) begin
              ready_reg <= 1'b1;
            end
          end
        end
      end

      assign busy_vec[gi]  = busy_reg;
      assign ready_vec[gi] = ready_reg;
      assign type_arr[gi]  = type_reg;
      assign rd_arr[gi]    = rd_reg;
      assign val_arr[gi]   = val_reg;
      assign prd_arr[gi]   = prd_reg;
      assign rel_arr[gi]   = rel_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      state_reg    <= ST_RUN;
      cmt0_rf_flag <= 1'b0;
      cmt0_rd      <= 5'd0;
      cmt0_id      <= '0;
      cmt0_val     <= 32'd0;
      cmt1_rf_flag <= 1'b0;
      cmt1_rd      <= 5'd0;
      cmt1_id      <= '0;
      cmt1_val     <= 32'd0;
      cmt_st_flag  <= 1'b0;
      cmt_st_id    <= '0;
      flush_flag   <= 1'b0;
      flush_stall  <= 1'b0;
      flush_pc     <= 32'd0;
    end else if (rdy) begin
      if (run) begin
        tail_reg  <= tail_reg + ROB_AW'(alloc_do);
        head_reg  <= head_reg + ROB_AW'(retire_cnt);
        count_reg <= count_reg + (ROB_AW + 1)'(alloc_do) - (ROB_AW + 1)'(retire_cnt);

        cmt0_rf_flag <= slot0_rf;
        if (slot0_rf) begin
          cmt0_rd  <= rd_arr[head_reg];
          cmt0_id  <= head_reg;
          cmt0_val <= val_arr[head_reg];
        end
        cmt1_rf_flag <= slot1_rf;
        if (slot1_rf) begin
          cmt1_rd  <= rd_arr[head1];
          cmt1_id  <= head1;
          cmt1_val <= val_arr[head1];
        end
        cmt_st_flag <= slot0_st;
        if (slot0_st) begin
          cmt_st_id <= head_reg;
        end

        flush_flag <= flush_req;
        if (flush_req) begin
          flush_stall <= 1'b1;
          flush_pc    <= rel_arr[head_reg];
          state_reg   <= ST_FLUSH;
        end
      end else begin
        cmt0_rf_flag <= 1'b0;
        cmt1_rf_flag <= 1'b0;
        cmt_st_flag  <= 1'b0;
        flush_flag   <= 1'b0;
        if (lsb_clear_done) begin
          head_reg    <= '0;
          tail_reg    <= '0;
          count_reg   <= '0;
          flush_stall <= 1'b0;
          state_reg   <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_wide_cmt.sv
// Directed bench for rob_wide_cmt: a dual-commit instance plus a single-commit
// instance sharing the same stimulus.
module tb_rob_wide_cmt;
  import rob_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n, rdy;
  logic          alloc_valid;
  logic [5:0]    alloc_code;
  logic [2:0]    alloc_type;
  logic [4:0]    alloc_rd;
  logic [31:0]   alloc_prd_pc;
  logic          ex_cdb_flag, ld_cdb_flag, st_rdy_flag, lsb_clear_done;
  logic [AW-1:0] ex_cdb_id, ld_cdb_id, st_rdy_id, q1_id, q2_id;
  logic [31:0]   ex_cdb_val, ex_cdb_rel_pc, ld_cdb_val;

  logic          alloc_ready, cmt0_rf_flag, cmt1_rf_flag, cmt_st_flag;
  logic          flush_flag, flush_stall, q1_ready, q2_ready;
  logic [AW-1:0] alloc_id, cmt0_id, cmt1_id, cmt_st_id;
  logic [4:0]    cmt0_rd, cmt1_rd;
  logic [31:0]   cmt0_val, cmt1_val, flush_pc, q1_val, q2_val;

  logic          s_alloc_ready, s_cmt0_rf_flag, s_cmt1_rf_flag, s_cmt_st_flag;
  logic          s_flush_flag, s_flush_stall, s_q1_ready, s_q2_ready;
  logic [AW-1:0] s_alloc_id, s_cmt0_id, s_cmt1_id, s_cmt_st_id;
  logic [4:0]    s_cmt0_rd, s_cmt1_rd;
  logic [31:0]   s_cmt0_val, s_cmt1_val, s_flush_pc, s_q1_val, s_q2_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rob_wide_cmt #(.DEPTH(DEPTH), .ROB_AW(AW), .CMT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_code(alloc_code), .alloc_type(alloc_type),
    .alloc_rd(alloc_rd), .alloc_prd_pc(alloc_prd_pc),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .ex_cdb_flag(ex_cdb_flag), .ex_cdb_id(ex_cdb_id), .ex_cdb_val(ex_cdb_val),
    .ex_cdb_rel_pc(ex_cdb_rel_pc),
    .ld_cdb_flag(ld_cdb_flag), .ld_cdb_id(ld_cdb_id), .ld_cdb_val(ld_cdb_val),
    .st_rdy_flag(st_rdy_flag), .st_rdy_id(st_rdy_id),
    .cmt0_rf_flag(cmt0_rf_flag), .cmt0_rd(cmt0_rd), .cmt0_id(cmt0_id), .cmt0_val(cmt0_val),
    .cmt1_rf_flag(cmt1_rf_flag), .cmt1_rd(cmt1_rd), .cmt1_id(cmt1_id), .cmt1_val(cmt1_val),
    .cmt_st_flag(cmt_st_flag), .cmt_st_id(cmt_st_id),
    .flush_flag(flush_flag), .flush_stall(flush_stall), .flush_pc(flush_pc),
    .lsb_clear_done(lsb_clear_done),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val)
  );

  rob_wide_cmt #(.DEPTH(DEPTH), .ROB_AW(AW), .CMT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_code(alloc_code), .alloc_type(alloc_type),
    .alloc_rd(alloc_rd), .alloc_prd_pc(alloc_prd_pc),
    .alloc_ready(s_alloc_ready), .alloc_id(s_alloc_id),
    .ex_cdb_flag(ex_cdb_flag), .ex_cdb_id(ex_cdb_id), .ex_cdb_val(ex_cdb_val),
    .ex_cdb_rel_pc(ex_cdb_rel_pc),
    .ld_cdb_flag(ld_cdb_flag), .ld_cdb_id(ld_cdb_id), .ld_cdb_val(ld_cdb_val),
    .st_rdy_flag(st_rdy_flag), .st_rdy_id(st_rdy_id),
    .cmt0_rf_flag(s_cmt0_rf_flag), .cmt0_rd(s_cmt0_rd), .cmt0_id(s_cmt0_id), .cmt0_val(s_cmt0_val),
    .cmt1_rf_flag(s_cmt1_rf_flag), .cmt1_rd(s_cmt1_rd), .cmt1_id(s_cmt1_id), .cmt1_val(s_cmt1_val),
    .cmt_st_flag(s_cmt_st_flag), .cmt_st_id(s_cmt_st_id),
    .flush_flag(s_flush_flag), .flush_stall(s_flush_stall), .flush_pc(s_flush_pc),
    .lsb_clear_done(lsb_clear_done),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(s_q1_ready), .q2_ready(s_q2_ready),
    .q1_val(s_q1_val), .q2_val(s_q2_val)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    alloc_valid = 1'b0; alloc_code = 6'd0; alloc_type = 3'd0; alloc_rd = 5'd0;
    alloc_prd_pc = 32'd0;
    ex_cdb_flag = 1'b0; ex_cdb_id = '0; ex_cdb_val = 32'd0; ex_cdb_rel_pc = 32'd0;
    ld_cdb_flag = 1'b0; ld_cdb_id = '0; ld_cdb_val = 32'd0;
    st_rdy_flag = 1'b0; st_rdy_id = '0; lsb_clear_done = 1'b0;
    q1_id = '0; q2_id = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy   = 1'b1;
    clear_in();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [2:0] t, input logic [4:0] r, input logic [31:0] p);
    alloc_valid = 1'b1; alloc_type = t; alloc_rd = r; alloc_prd_pc = p;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic ex_send(input logic [AW-1:0] id, input logic [31:0] v, input logic [31:0] rel);
    ex_cdb_flag = 1'b1; ex_cdb_id = id; ex_cdb_val = v; ex_cdb_rel_pc = rel;
    tick();
    ex_cdb_flag = 1'b0;
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    rdy   = 1'b1;
    clear_in();
    tick();
    check_val("rst cmt0_flag", 32'(cmt0_rf_flag), 32'd0);
    check_val("rst cmt1_flag", 32'(cmt1_rf_flag), 32'd0);
    check_val("rst st_flag", 32'(cmt_st_flag), 32'd0);
    check_val("rst flush_flag", 32'(flush_flag), 32'd0);
    check_val("rst flush_stall", 32'(flush_stall), 32'd0);
    check_val("rst flush_pc", flush_pc, 32'd0);
    check_val("rst alloc_id", 32'(alloc_id), 32'd0);
    check_val("rst q1_ready", 32'(q1_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Dual commit of two ALU ops
    push(TYP_ALU, 5'd1, 32'd0);
    check_val("t1 alloc_id", 32'(alloc_id), 32'd1);
    push(TYP_ALU, 5'd2, 32'd0);
    push(TYP_ALU, 5'd3, 32'd0);
    check_val("t1 alloc_id3", 32'(alloc_id), 32'd3);
    ex_cdb_flag = 1'b1; ex_cdb_id = 4'd0; ex_cdb_val = 32'd5;
    ld_cdb_flag = 1'b1; ld_cdb_id = 4'd1; ld_cdb_val = 32'd7;
    tick();
    clear_in();
    #1;
    check_val("t1 q1_ready", 32'(q1_ready), 32'd1);
    check_val("t1 q1_val", q1_val, 32'd5);
    check_val("t1 early cmt0", 32'(cmt0_rf_flag), 32'd0);
    tick();
    check_val("t1 cmt0_flag", 32'(cmt0_rf_flag), 32'd1);
    check_val("t1 cmt0_id", 32'(cmt0_id), 32'd0);
    check_val("t1 cmt0_val", cmt0_val, 32'd5);
    check_val("t1 cmt0_rd", 32'(cmt0_rd), 32'd1);
    check_val("t1 cmt1_flag", 32'(cmt1_rf_flag), 32'd1);
    check_val("t1 cmt1_id", 32'(cmt1_id), 32'd1);
    check_val("t1 cmt1_val", cmt1_val, 32'd7);
    check_val("t1 q1_ready retired", 32'(q1_ready), 32'd0);
    ex_send(4'd2, 32'd9, 32'd0);
    check_val("t1 pulse cmt0", 32'(cmt0_rf_flag), 32'd0);
    tick();
    check_val("t1 head2 cmt0_id", 32'(cmt0_id), 32'd2);
    check_val("t1 head2 cmt0_val", cmt0_val, 32'd9);
    check_val("t1 head2 cmt1_flag", 32'(cmt1_rf_flag), 32'd0);

    // Fill to DEPTH, overflow drop, re-raise alloc_ready
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid = 1'b1; alloc_type = TYP_ALU; alloc_rd = 5'(i + 1);
      #1;
      check_val($sformatf("t2 alloc_id %0d", i), 32'(alloc_id), 32'(i));
      if (i >= DEPTH - 2) check_val($sformatf("t2 alloc_ready %0d", i), 32'(alloc_ready), 32'(i < DEPTH - 1));
      tick();
    end
    alloc_rd = 5'd31;
    #1;
    check_val("t2 full alloc_ready", 32'(alloc_ready), 32'd0);
    tick();
    alloc_valid = 1'b0;
    check_val("t2 dropped alloc_id", 32'(alloc_id), 32'd0);
    ex_send(4'd0, 32'h11, 32'd0);
    tick();
    check_val("t2 cmt0_flag", 32'(cmt0_rf_flag), 32'd1);
    check_val("t2 cmt0_rd", 32'(cmt0_rd), 32'd1);
    check_val("t2 cmt0_val", cmt0_val, 32'h11);
    check_val("t2 cmt1_flag", 32'(cmt1_rf_flag), 32'd0);
    check_val("t2 alloc_ready back", 32'(alloc_ready), 32'd1);

    // Branch mispredict and flush handshake
    do_reset();
    push(TYP_BR, 5'd0, 32'h100);
    push(TYP_ALU, 5'd4, 32'd0);
    ex_send(4'd0, 32'd0, 32'h200);
    tick();
    check_val("t3 flush_flag", 32'(flush_flag), 32'd1);
    check_val("t3 flush_stall", 32'(flush_stall), 32'd1);
    check_val("t3 flush_pc", flush_pc, 32'h200);
    check_val("t3 br no rf", 32'(cmt0_rf_flag), 32'd0);
    alloc_valid = 1'b1; alloc_type = TYP_ALU;
    tick();
    alloc_valid = 1'b0;
    check_val("t3 flush pulse", 32'(flush_flag), 32'd0);
    check_val("t3 stall held", 32'(flush_stall), 32'd1);
    check_val("t3 alloc ignored", 32'(alloc_id), 32'd2);
    lsb_clear_done = 1'b1;
    tick();
    lsb_clear_done = 1'b0;
    q1_id = 4'd0;
    #1;
    check_val("t3 stall cleared", 32'(flush_stall), 32'd0);
    check_val("t3 alloc_id 0", 32'(alloc_id), 32'd0);
    check_val("t3 entry cleared", 32'(q1_ready), 32'd0);

    // Store at head with ALU behind it; CMT_W=1 instance lags one cycle
    do_reset();
    push(TYP_ST, 5'd0, 32'd0);
    push(TYP_ALU, 5'd5, 32'd0);
    st_rdy_flag = 1'b1; st_rdy_id = 4'd0;
    ex_cdb_flag = 1'b1; ex_cdb_id = 4'd1; ex_cdb_val = 32'h33;
    tick();
    clear_in();
    tick();
    check_val("t4 st_flag", 32'(cmt_st_flag), 32'd1);
    check_val("t4 st_id", 32'(cmt_st_id), 32'd0);
    check_val("t4 cmt0 none", 32'(cmt0_rf_flag), 32'd0);
    check_val("t4 cmt1_flag", 32'(cmt1_rf_flag), 32'd1);
    check_val("t4 cmt1_id", 32'(cmt1_id), 32'd1);
    check_val("t4 cmt1_val", cmt1_val, 32'h33);
    check_val("t4 w1 st_flag", 32'(s_cmt_st_flag), 32'd1);
    check_val("t4 w1 cmt1 none", 32'(s_cmt1_rf_flag), 32'd0);
    check_val("t4 w1 cmt0 none", 32'(s_cmt0_rf_flag), 32'd0);
    push(TYP_BR, 5'd0, 32'h300);
    check_val("t4 w1 cmt0_flag", 32'(s_cmt0_rf_flag), 32'd1);
    check_val("t4 w1 cmt0_id", 32'(s_cmt0_id), 32'd1);
    check_val("t4 w1 cmt0_val", s_cmt0_val, 32'h33);
    check_val("t4 dual idle", 32'(cmt1_rf_flag), 32'd0);
    ex_send(4'd2, 32'd0, 32'h300);
    push(TYP_ALU, 5'd6, 32'd0);
    check_val("t4 br ok no flush", 32'(flush_flag), 32'd0);
    ex_send(4'd3, 32'h66, 32'd0);
    tick();
    check_val("t4 after br cmt0_id", 32'(cmt0_id), 32'd3);
    check_val("t4 after br cmt0_val", cmt0_val, 32'h66);

    // Wrap-around over 20 instructions, then bus collision
    do_reset();
    for (int k = 0; k < 20; k++) begin
      push(TYP_ALU, 5'(k + 1), 32'd0);
      check_val($sformatf("t5 alloc_id k%0d", k), 32'(alloc_id), 32'((k + 1) % DEPTH));
      ex_send(AW'(k % DEPTH), 32'(k * 3 + 100), 32'd0);
      q1_id = AW'(k % DEPTH);
      #1;
      check_val($sformatf("t5 q1_val k%0d", k), q1_val, 32'(k * 3 + 100));
      tick();
      check_val($sformatf("t5 cmt0_id k%0d", k), 32'(cmt0_id), 32'(k % DEPTH));
    end
    push(TYP_ALU, 5'd7, 32'd0);
    ex_cdb_flag = 1'b1; ex_cdb_id = 4'd4; ex_cdb_val = 32'hAA;
    ld_cdb_flag = 1'b1; ld_cdb_id = 4'd4; ld_cdb_val = 32'hBB;
    st_rdy_flag = 1'b1; st_rdy_id = 4'd9;
    tick();
    clear_in();
    q1_id = 4'd4; q2_id = 4'd9;
    #1;
    check_val("t5 ex wins", q1_val, 32'hAA);
    check_val("t5 idle entry ignored", 32'(q2_ready), 32'd0);

    // rdy freeze with mispredict pending, then async reset mid-FLUSH
    do_reset();
    push(TYP_JMP, 5'd1, 32'h40);
    ex_send(4'd0, 32'h44, 32'h80);
    rdy = 1'b0;
    alloc_valid = 1'b1; alloc_type = TYP_ALU;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val($sformatf("t6 frozen flush c%0d", c), 32'(flush_flag), 32'd0);
      check_val($sformatf("t6 frozen alloc c%0d", c), 32'(alloc_id), 32'd1);
    end
    alloc_valid = 1'b0;
    rdy = 1'b1;
    tick();
    check_val("t6 flush_flag", 32'(flush_flag), 32'd1);
    check_val("t6 flush_pc", flush_pc, 32'h80);
    check_val("t6 jmp rf", 32'(cmt0_rf_flag), 32'd1);
    check_val("t6 jmp val", cmt0_val, 32'h44);
    rdy = 1'b0;
    tick();
    tick();
    check_val("t6 flag held", 32'(flush_flag), 32'd1);
    check_val("t6 stall held", 32'(flush_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t6 rst flush_flag", 32'(flush_flag), 32'd0);
    check_val("t6 rst flush_stall", 32'(flush_stall), 32'd0);
    check_val("t6 rst flush_pc", flush_pc, 32'd0);
    check_val("t6 rst cmt0", 32'(cmt0_rf_flag), 32'd0);
    check_val("t6 rst q1_ready", 32'(q1_ready), 32'd0);
    rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    push(TYP_ALU, 5'd2, 32'd0);
    check_val("t6 run after rst", 32'(alloc_id), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rob_wide_cmt.md
Name: rob_wide_cmt

Overview:
- Parametrised reorder buffer that supersedes the single-commit ROB.
- Depth, tag width and commit width (1 or 2) are parameters.
- Tracks in-flight instructions from decode to commit, takes results from two CDBs plus store-ready, and retires in program order to the register file and LSB.
- On a head branch/jump mispredict, flushes after a handshake with the LSB.

Parameters:
- DEPTH, 16, entry count; power of 2, at least 4.
- ROB_AW, 4, tag width; equals log2(DEPTH).
- CMT_W, 2, maximum commits per cycle; 1 or 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- rdy  in  1  global enable; low freezes all state.
- alloc_valid  in  1  decode allocates one entry this cycle.
- alloc_code  in  6  opcode.
- alloc_type  in  3  type: ALU/BR/JMP/LD/ST.
- alloc_rd  in  5  destination register.
- alloc_prd_pc  in  32  predicted next PC.
- alloc_ready  out  1  an entry is guaranteed free for next cycle's allocation.
- alloc_id  out  ROB_AW  tag that the next allocation receives (the tail index).
- ex_cdb_flag/ex_cdb_id/ex_cdb_val/ex_cdb_rel_pc  in  1/ROB_AW/32/32  ALU result bus.
- ld_cdb_flag/ld_cdb_id/ld_cdb_val  in  1/ROB_AW/32  load result bus.
- st_rdy_flag/st_rdy_id  in  1/ROB_AW  store address and data resolved.
- cmt0_rf_flag/cmt0_rd/cmt0_id/cmt0_val  out  1/5/ROB_AW/32  RF commit, slot 0.
- cmt1_rf_flag/cmt1_rd/cmt1_id/cmt1_val  out  1/5/ROB_AW/32  RF commit, slot 1.
- cmt_st_flag/cmt_st_id  out  1/ROB_AW  store commit to LSB.
- flush_flag  out  1  one-cycle mispredict pulse.
- flush_stall  out  1  high while waiting for the LSB clear.
- flush_pc  out  32  redirect PC.
- lsb_clear_done  in  1  LSB has discarded its speculative entries.
- q1_id/q2_id  in  ROB_AW  operand lookup tags.
- q1_ready/q2_ready  out  1  entry result valid.
- q1_val/q2_val  out  32  entry result.

Behaviour:
- Reset (rst_n low, async):
  - head=0, tail=0, count=0.
  - All busy/ready bits 0; state RUN.
  - All outputs 0, including flush_pc and every cmt flag.
- rdy low: every register holds, including the output flags; consumers gate with rdy.
- Outputs alloc_id=tail, q*_ready=ready[q*_id] and q*_val=val[q*_id] are combinational from registered state; there is no CDB bypass.
- alloc_ready = (DEPTH-count-alloc_valid) >= 1. Commits in the current cycle are ignored, which is conservative.
- RUN state, each rdy cycle:
  - Allocation:
    - alloc_valid writes entry tail with busy=1, ready=0 and the payload.
    - tail=(tail+1) mod DEPTH; count increments.
    - alloc_valid while count==DEPTH is a protocol error and is dropped.
  - CDB and store-ready:
    - ex_cdb writes val, rel_pc and ready=1 to busy entry ex_cdb_id.
    - ld_cdb writes val and ready=1.
    - st_rdy sets ready=1.
    - Writes to non-busy entries are ignored.
    - If ex_cdb and ld_cdb carry the same id, ex_cdb wins.
  - Commit reads registered ready, so an entry completed in cycle N commits at the earliest in N+1.
  - Slot 0 commits head when busy and ready:
    - ALU/LD: cmt0_rf_flag=1 with rd, val, id.
    - ST: cmt_st_flag=1, cmt_st_id=head.
    - JMP: cmt0_rf_flag=1, plus the mispredict check.
    - BR: no RF write, plus the mispredict check.
  - Mispredict check:
    - If prd_pc==rel_pc, retire normally.
    - Otherwise: flush_flag=1 for one cycle, flush_stall=1, flush_pc=rel_pc, state goes to FLUSH.
    - Head does not advance.
  - Slot 1 (CMT_W==2) commits head+1 only when all of these hold:
    - slot 0 commits a non-BR/JMP entry;
    - head+1 is busy and ready;
    - head+1 type is ALU or LD.
    - It then drives cmt1_* and retires together with slot 0.
  - Retirement effects:
    - Retired entries get busy=0, ready=0.
    - head advances by the number retired, modulo DEPTH.
    - count = count + alloc - retired.
  - Any unused commit flag is 0 that cycle; flags are one-cycle pulses.
- FLUSH state:
  - flush_flag=0, all cmt flags 0.
  - alloc, CDB and st_rdy are ignored.
  - On lsb_clear_done: busy=0 and ready=0 everywhere, head=tail=count=0, flush_stall=0, state returns to RUN.
- Wrap-around: pointers are ROB_AW bits wide and wrap naturally. Full versus empty is decided by count (ROB_AW+1 bits), never by pointer compare.
- Reset asserted during FLUSH returns to RUN and drops flush_stall asynchronously.

Decomposition:
- Shared package rob_pkg holds:
  - type encodings ALU=0, BR=1, JMP=2, LD=3, ST=4;
  - state encoding RUN/FLUSH;
  - True/False constants.
- One sub-module, rob_cmt_sel: combinational selection of slot 0/1 and mispredict detection from the head/head+1 entry fields. It returns retire count, flags and flush request.
- The top level keeps storage, pointers and the FSM.

Test Plan:
- Reset then allocate 3 ALU ops (ids 0,1,2), ex_cdb ids 0 and 1 with vals 5 and 7 -> next cycle cmt0 id0 val5 and cmt1 id1 val7 together; head=2.
- Fill DEPTH=16 with no completions -> alloc_ready drops when count=15 with alloc_valid high; a 17th alloc_valid is dropped; commit of id0 re-raises alloc_ready.
- BR at head with prd_pc=0x100 and ex rel_pc=0x200 -> flush_flag pulses once, flush_pc=0x200, flush_stall holds; after lsb_clear_done: count=0, alloc_id=0.
- ST at head and ALU at head+1, both ready -> cmt_st_flag=1 with id head; the ALU uses slot 1 the same cycle; with CMT_W=1 the ALU commits one cycle later.
- Wrap: allocate and retire 20 instructions on DEPTH=16 -> ids wrap 15 to 0; q1_id=3 returns the latest value after completion; ex and ld on the same id in one cycle -> the ex value is stored.
- Hold rdy low for 5 cycles with a mispredict pending, then assert rst_n low mid-FLUSH -> state frozen during rdy low; on reset all outputs return to 0 immediately.
